// File: rtl/audio_source_arbiter.sv
// Per-frame round-robin owner select plus req/ack stereo fetch for the AC'97 PCM slot; optional SOFT_SWITCH_EN mutes after owner changes.
// Latency: sample registered one clock after owner ack (>= 3 clocks after ready rise); a slow owner times out with an underrun pulse.
module audio_source_arbiter #(
  parameter int NUM_SRC     = 3,
  parameter int W           = 20,
  parameter int TIMEOUT     = 64,
  parameter int MUTE_FRAMES = 4
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 ready,
  input  logic [NUM_SRC-1:0]   src_req,
  output logic [NUM_SRC-1:0]   src_grant,
  output logic [NUM_SRC-1:0]   fetch_req,
  input  logic [NUM_SRC-1:0]   fetch_ack,
  input  logic [NUM_SRC*W-1:0] src_left,
  input  logic [NUM_SRC*W-1:0] src_right,
  output logic [W-1:0]         left_out,
  output logic [W-1:0]         right_out,
  output logic                 underrun
);
  localparam int PW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CNT_MAX = (TIMEOUT > MUTE_FRAMES) ? TIMEOUT : MUTE_FRAMES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, ARB, FETCH} state_t;

  state_t             state_q;
  logic               ready_q;
  logic [NUM_SRC-1:0] grant_q;
  logic [NUM_SRC-1:0] fetch_req_q;
  logic [PW-1:0]      ptr_q;
  logic [CW-1:0]      cnt_q;
  logic [W-1:0]       left_q;
  logic [W-1:0]       right_q;
  logic               underrun_q;
`ifdef SOFT_SWITCH_EN
  logic [CW-1:0]      mute_q;
`endif

  logic               frame;
  logic               owner_ack;
  logic [NUM_SRC-1:0] grant_d;
  logic [PW-1:0]      ptr_d;
  logic [PW-1:0]      pidx;
  logic [W-1:0]       own_left;
  logic [W-1:0]       own_right;

  assign frame     = ready & ~ready_q;
  assign owner_ack = |(fetch_req_q & fetch_ack);

  // The pointer always names the current owner, so it doubles as the sample mux select.
  always_comb begin
    own_left  = '0;
    own_right = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ptr_q == PW'(i)) begin
        own_left  = src_left[i*W +: W];
        own_right = src_right[i*W +: W];
      end
    end
  end

  // Sticky owner first; otherwise descending scan so the lowest offset from ptr+1 wins.
  always_comb begin
    grant_d = '0;
    ptr_d   = ptr_q;
    pidx    = '0;
    if (|(grant_q & src_req)) begin
      grant_d = grant_q;
    end else begin
      for (int i = NUM_SRC; i >= 1; i--) begin
        pidx = PW'((int'(ptr_q) + i) % NUM_SRC);
        if (src_req[pidx]) begin
          grant_d       = '0;
          grant_d[pidx] = 1'b1;
          ptr_d         = pidx;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      grant_q     <= '0;
      fetch_req_q <= '0;
      ptr_q       <= PW'(NUM_SRC - 1);
      cnt_q       <= '0;
      left_q      <= '0;
      right_q     <= '0;
      underrun_q  <= 1'b0;
`ifdef SOFT_SWITCH_EN
      mute_q      <= '0;
`endif
    end else begin
      ready_q    <= ready;
      underrun_q <= frame && (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (frame) state_q <= ARB;
        end
        ARB: begin
          grant_q     <= grant_d;
          ptr_q       <= ptr_d;
          fetch_req_q <= grant_d;
          cnt_q       <= '0;
          state_q     <= (|grant_d) ? FETCH : IDLE;
          if (!(|grant_d)) begin
            left_q  <= '0;
            right_q <= '0;
          end
`ifdef SOFT_SWITCH_EN
          if (grant_d != grant_q) begin
            mute_q  <= CW'(MUTE_FRAMES);
            left_q  <= '0;
            right_q <= '0;
          end else if (mute_q != '0) begin
            mute_q <= mute_q - 1'b1;
          end
`endif
        end
        FETCH: begin
          if (owner_ack) begin
            fetch_req_q <= '0;
            state_q     <= IDLE;
`ifdef SOFT_SWITCH_EN
            if (mute_q == '0) begin
              left_q  <= own_left;
              right_q <= own_right;
            end
`else
            left_q  <= own_left;
            right_q <= own_right;
`endif
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            fetch_req_q <= '0;
            underrun_q  <= 1'b1;
            state_q     <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign src_grant = grant_q;
  assign fetch_req = fetch_req_q;
  assign left_out  = left_q;
  assign right_out = right_q;
  assign underrun  = underrun_q;
endmodule

// File: tb/tb_audio_source_arbiter.sv
// Frame-level bench for audio_source_arbiter: directed frames then random ones, each compared with a
// transaction-level model of ownership, fetch duration, underrun count and output sample.
module tb_audio_source_arbiter;
  localparam int N  = 3;
  localparam int W  = 20;
  localparam int TO = 64;
  localparam int MF = 4;

  logic           clock     = 1'b0;
  logic           reset_n   = 1'b0;
  logic           ready     = 1'b0;
  logic [N-1:0]   src_req   = '0;
  logic [N-1:0]   fetch_ack = '0;
  logic [N*W-1:0] src_left  = '0;
  logic [N*W-1:0] src_right = '0;
  logic [N-1:0]   src_grant;
  logic [N-1:0]   fetch_req;
  logic [W-1:0]   left_out;
  logic [W-1:0]   right_out;
  logic           underrun;

  int          n_cmp    = 0;
  int          n_err    = 0;
  int          own      = -1;
  int          ptr      = N - 1;
  int          mute     = 0;
  logic [W-1:0] exp_l   = '0;
  logic [W-1:0] exp_r   = '0;
  bit          rand_dat = 1'b1;

  audio_source_arbiter #(.NUM_SRC(N), .W(W), .TIMEOUT(TO), .MUTE_FRAMES(MF)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .ready     (ready),
    .src_req   (src_req),
    .src_grant (src_grant),
    .fetch_req (fetch_req),
    .fetch_ack (fetch_ack),
    .src_left  (src_left),
    .src_right (src_right),
    .left_out  (left_out),
    .right_out (right_out),
    .underrun  (underrun)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    own   = -1;
    ptr   = N - 1;
    mute  = 0;
    exp_l = '0;
    exp_r = '0;
  endtask

  task automatic check_idle_zero(input string tag);
    check_eq({tag, "_grant"}, 32'(src_grant), 32'd0);
    check_eq({tag, "_freq"},  32'(fetch_req), 32'd0);
    check_eq({tag, "_left"},  32'(left_out),  32'd0);
    check_eq({tag, "_right"}, 32'(right_out), 32'd0);
    check_eq({tag, "_urun"},  32'(underrun),  32'd0);
  endtask

  // One frame: ready rise, owner acks after ack_dly fetch cycles (>= TO means never),
  // optional second ready rise at sample glitch, optional reset at sample rst_at.
  task automatic do_frame(input logic [N-1:0] req, input int ack_dly, input int glitch, input int rst_at);
    int old, busy, bad, ur, exp_busy, exp_ur, g;
    logic [N-1:0] oh;
    if (rand_dat) begin
      for (int i = 0; i < N; i++) begin
        src_left[i*W +: W]  = W'($urandom);
        src_right[i*W +: W] = W'($urandom);
      end
    end
    src_req = req;
    ready   = 1'b1;
    @(negedge clock);
    ready = 1'b0;

    old = own;
    if (!(own >= 0 && req[own])) begin
      own = -1;
      for (int i = 1; i <= N; i++) begin
        if (own < 0 && req[(ptr + i) % N]) begin
          own = (ptr + i) % N;
          ptr = own;
        end
      end
    end
    if (own < 0) begin
      exp_l = '0;
      exp_r = '0;
    end
`ifdef SOFT_SWITCH_EN
    if (own != old) begin
      mute  = MF;
      exp_l = '0;
      exp_r = '0;
    end else if (mute > 0) begin
      mute--;
    end
`endif
    oh = '0;
    if (own >= 0) oh[own] = 1'b1;
    g = (own < 0) ? -1 : glitch;

    @(negedge clock);
    check_eq("grant", 32'(src_grant), 32'(oh));
    busy = 0;
    bad  = 0;
    ur   = 0;
    for (int s = 0; s < TO + 4; s++) begin
      if (fetch_req != '0) busy++;
      if (fetch_req != '0 && fetch_req != oh) bad++;
      if (underrun) ur++;
      if (s == rst_at) begin
        reset_n   = 1'b0;
        fetch_ack = '0;
        @(negedge clock);
        check_idle_zero("midrst");
        reset_n = 1'b1;
        model_reset();
        return;
      end
      ready     = (s == g);
      fetch_ack = '0;
      if (s < ack_dly) fetch_ack = N'($urandom) & ~oh;
      else if (s == ack_dly) fetch_ack = oh;
      if (s == 1) src_req = N'($urandom);
      @(negedge clock);
    end
    fetch_ack = '0;
    ready     = 1'b0;

    exp_busy = 0;
    exp_ur   = 0;
    if (own >= 0) begin
      if (ack_dly < TO) begin
        exp_busy = ack_dly + 1;
`ifdef SOFT_SWITCH_EN
        if (mute == 0) begin
          exp_l = src_left[own*W +: W];
          exp_r = src_right[own*W +: W];
        end
`else
        exp_l = src_left[own*W +: W];
        exp_r = src_right[own*W +: W];
`endif
      end else begin
        exp_busy = TO;
        exp_ur   = 1;
      end
    end
    if (g >= 0) exp_ur++;
    check_eq("fetch_cycles", 32'(busy), 32'(exp_busy));
    check_eq("fetch_onehot", 32'(bad), 32'd0);
    check_eq("underruns",    32'(ur), 32'(exp_ur));
    check_eq("left_out",     32'(left_out), 32'(exp_l));
    check_eq("right_out",    32'(right_out), 32'(exp_r));
  endtask

  initial begin
    int ad, gl, ra, lim;
    repeat (2) @(negedge clock);
    check_idle_zero("reset");
    reset_n = 1'b1;
    @(negedge clock);

    rand_dat = 1'b0;
    src_left[0 +: W]  = 20'h12345;
    src_right[0 +: W] = 20'h0ABCD;
    do_frame(3'b001, 2, -1, -1);
    rand_dat = 1'b1;

    repeat (3) do_frame(3'b111, 3, -1, -1);
    do_frame(3'b110, 5, -1, -1);
    do_frame(3'b110, 5, -1, -1);

    rand_dat = 1'b0;
    src_left[0 +: W]  = 20'h00100;
    src_right[0 +: W] = 20'h00100;
    do_frame(3'b001, 4, -1, -1);
    do_frame(3'b001, 1000, -1, -1);
    rand_dat = 1'b1;

    do_frame(3'b000, 0, -1, -1);
    do_frame(3'b001, 30, 8, -1);
    do_frame(3'b001, TO - 1, -1, -1);
    do_frame(3'b001, TO, -1, -1);

    do_frame(3'b001, 3, -1, -1);
    do_frame(3'b001, 3, -1, -1);
    repeat (5) do_frame(3'b100, 3, -1, -1);
    do_frame(3'b010, 40, -1, 20);

    for (int f = 0; f < 40; f++) begin
      ad  = ($urandom % 8 == 0) ? int'($urandom_range(TO, TO + 6)) : int'($urandom_range(0, 20));
      lim = (ad < TO) ? ad : TO;
      gl  = ($urandom % 6 == 0 && lim >= 2) ? int'($urandom_range(0, lim - 2)) : -1;
      ra  = ($urandom % 15 == 0) ? int'($urandom_range(0, 5)) : -1;
      do_frame(N'($urandom), ad, gl, ra);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
